// File: rtl/uart_rx_core.sv
// rtl/uart_rx_core.sv - UART receiver: start, 8 data bits LSB first, parity, stop
// Oversamples a synchronized line; completed bytes are held for a valid/ack consumer.
module uart_rx_core #(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_ODD   = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       data_in,
  output logic [7:0] data_out,
  output logic       rx_valid,
  input  logic       rx_ack,
  output logic       parity_err,
  output logic       frame_err,
  output logic       overrun,
  output logic       rx_busy
);

  localparam int            CW        = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic          ODD       = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_IDLE
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [2:0]    bitcnt_q, bitcnt_d;
  logic          sync1_q, sync2_q;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          stop_q, stop_d;
  logic          done_q, done_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          perr_q, perr_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;
  logic          busy_q, busy_d;
  logic          rxs;

  assign rxs = sync2_q;

  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    bitcnt_d = bitcnt_q;
    shift_d  = shift_q;
    par_d    = par_q;
    stop_d   = stop_q;
    done_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!rxs) begin
          state_d = ST_START;
          cyc_d   = '0;
        end
      end
      ST_START: begin
        if (cyc_q == HALF_LAST) begin
          cyc_d    = '0;
          bitcnt_d = '0;
          state_d  = rxs ? ST_IDLE : ST_DATA;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      ST_DATA: begin
        if (cyc_q == BIT_LAST) begin
          cyc_d             = '0;
          shift_d[bitcnt_q] = rxs;
          if (bitcnt_q == 3'd7) begin
            state_d = ST_PARITY;
          end else begin
            bitcnt_d = bitcnt_q + 1'b1;
          end
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      ST_PARITY: begin
        if (cyc_q == BIT_LAST) begin
          cyc_d   = '0;
          par_d   = rxs;
          state_d = ST_STOP;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      ST_STOP: begin
        if (cyc_q == BIT_LAST) begin
          cyc_d   = '0;
          stop_d  = rxs;
          done_d  = 1'b1;
          state_d = rxs ? ST_IDLE : ST_WAIT_IDLE;
        end else begin
          cyc_d = cyc_q + 1'b1;
        end
      end
      ST_WAIT_IDLE: begin
        // A held-low line (break) must see a high level before a new frame can start.
        if (rxs) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    data_d  = data_q;
    valid_d = valid_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q;
    if (done_q) begin
      data_d  = shift_q;
      perr_d  = (^shift_q) ^ par_q ^ ODD;
      ferr_d  = ~stop_q;
      valid_d = 1'b1;
      if (valid_q && !rx_ack) begin
        ovr_d = 1'b1;
      end
    end else if (rx_ack) begin
      valid_d = 1'b0;
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      cyc_q    <= '0;
      bitcnt_q <= '0;
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      shift_q  <= '0;
      par_q    <= 1'b0;
      stop_q   <= 1'b1;
      done_q   <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      ovr_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      bitcnt_q <= bitcnt_d;
      sync1_q  <= data_in;
      sync2_q  <= sync1_q;
      shift_q  <= shift_d;
      par_q    <= par_d;
      stop_q   <= stop_d;
      done_q   <= done_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
      ovr_q    <= ovr_d;
      busy_q   <= busy_d;
    end
  end

  assign data_out   = data_q;
  assign rx_valid   = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;
  assign rx_busy    = busy_q;

endmodule

// File: doc/uart_rx_core.md
UART_RX_CORE -- requirements
Module: uart_rx_core

Interface
REQ-001 The block SHALL have one parameter: CLKS_PER_BIT, default 16, giving clock cycles per serial bit; legal values are even integers >= 4.
REQ-002 The block SHALL have one parameter: PARITY_ODD, default 0, where 0 selects even parity and 1 selects odd parity.
REQ-003 Port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, reset; synchronous and active-high.
REQ-005 Port data_in, input, 1, asynchronous serial line; idles high.
REQ-006 Port data_out, output, 8, last received data byte.
REQ-007 Port rx_valid, output, 1, high while data_out holds an unacknowledged byte.
REQ-008 Port rx_ack, input, 1, consumer acknowledge; clears rx_valid.
REQ-009 Port parity_err, output, 1, parity mismatch flag for the byte in data_out.
REQ-010 Port frame_err, output, 1, stop bit sampled low for the byte in data_out.
REQ-011 Port overrun, output, 1, sticky flag: a byte completed while rx_valid was high.
REQ-012 Port rx_busy, output, 1, high in any state other than IDLE.

Function
REQ-013 Frame format SHALL be: 1 start bit (0), 8 data bits LSB first, 1 parity bit, 1 stop bit (1).
REQ-014 data_in SHALL pass through a 2-flop synchronizer; all logic uses the synchronized value rxs.
REQ-015 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP and WAIT_IDLE; a bit counter (0..7) and a cycle counter (0..CLKS_PER_BIT-1) SHALL be used.
REQ-016 IDLE: on rxs==0, go to START and clear the cycle counter.
REQ-017 START: on cycle count CLKS_PER_BIT/2-1, sample rxs; 0 -> DATA with counters cleared; 1 -> IDLE (false start, no flags change).
REQ-018 DATA: each CLKS_PER_BIT cycles, sample rxs into shift register bit[bitcnt]; after bit 7 -> PARITY.
REQ-019 PARITY: after CLKS_PER_BIT cycles, sample the parity bit; -> STOP.
REQ-020 STOP: after CLKS_PER_BIT cycles, sample the stop bit; on the next clock, load data_out, parity_err, frame_err and set rx_valid; -> IDLE if stop==1, else -> WAIT_IDLE.
REQ-021 WAIT_IDLE: remain until rxs==1, then -> IDLE (break/line-low never retriggers a frame).
REQ-022 parity_err SHALL be (XOR of 8 data bits XOR parity bit XOR PARITY_ODD) != 0.
REQ-023 Latency: rx_valid rises exactly 1 cycle after the stop-bit sample cycle.
REQ-024 rx_valid SHALL clear on the cycle after rx_ack is sampled high; rx_ack while rx_valid is low has no effect.
REQ-025 If a frame completes while rx_valid is high and rx_ack is not high that cycle, data_out and the error flags SHALL be overwritten, rx_valid stays high, and overrun is set.
REQ-026 If completion and rx_ack coincide, the new byte is loaded, rx_valid stays high, and overrun is not set.
REQ-027 overrun SHALL clear only on rst.
REQ-028 Receiving SHALL continue regardless of rx_valid; no frame is dropped by the FSM.

Reset
REQ-029 On rst high at a clock edge: state IDLE, counters 0, synchronizer flops 1, data_out 8'h00, rx_valid 0, parity_err 0, frame_err 0, overrun 0, rx_busy 0.
REQ-030 rst asserted mid-frame SHALL abort the frame with no output update; reception restarts at the next start bit after release.

Verification
REQ-031 CLKS_PER_BIT=16, even parity, send 8'hA5 with parity 0, stop 1 -> data_out=8'hA5, rx_valid=1, parity_err=0, frame_err=0, 1 cycle after stop sample.
REQ-032 Send 8'h01 with parity bit 0 (wrong) -> data_out=8'h01, parity_err=1, frame_err=0.
REQ-033 Send 8'h3C with stop bit 0, line held low 40 bit-times -> frame_err=1, one rx_valid only, FSM in WAIT_IDLE until line high.
REQ-034 Low glitch of 4 cycles on idle line -> returns to IDLE, rx_valid stays 0, rx_busy high for <= 8 cycles.
REQ-035 Send 8'h11 then 8'h22 with no rx_ack -> data_out=8'h22, overrun=1; repeat with rx_ack pulsed in completion cycle -> overrun stays 0.
REQ-036 Assert rst during bit 4 of 8'hFF frame -> no rx_valid; next frame 8'h5A received correctly.
